// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, digit geometry and default tick divider for the timer control block
package timer_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BUF_W = DIGIT_W * NUM_DIGITS;
  localparam int DEF_TICK_DIV = 100;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: mod-TICK_DIV counter (clk, rst, i_clr sync clear, i_en advance) flagging terminal count on o_tc
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] r_cnt;
  assign o_tc = r_cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tc ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: keypad MM:SS entry buffer, load/run/pause/done FSM and count_en tick toward the BCD counter chain
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               start,
  input  logic               stop_clear,
  input  logic               zero_L,
  output logic [BUF_W-1:0]   load_value,
  output logic               load,
  output logic               count_en,
  output logic               running,
  output logic               done
);
  state_t r_state, w_nxt;
  logic [BUF_W-1:0] r_buf;
  logic [2:0] r_cnt;
  logic w_tc, w_entry, w_go, w_acc;
  assign w_entry = r_state == IDLE || r_state == ENTRY;
  assign w_go = w_entry && start && !stop_clear && r_buf != '0;
  assign w_acc = w_entry && digit_valid && digit <= 4'd9 && r_cnt < 3'(NUM_DIGITS) && !stop_clear && !w_go;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE, ENTRY: w_nxt = stop_clear ? IDLE : w_go ? LOAD : w_acc ? ENTRY : r_state;
      LOAD:        w_nxt = RUN;
      RUN:         w_nxt = stop_clear ? PAUSE : !zero_L ? DONE : RUN;
      PAUSE:       w_nxt = stop_clear ? IDLE : start ? RUN : PAUSE;
      DONE:        w_nxt = (start || stop_clear) ? IDLE : DONE;
      default:     w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt == IDLE) begin
        r_buf <= '0;
        r_cnt <= '0;
      end else if (w_acc) begin
        r_buf <= {r_buf[BUF_W-DIGIT_W-1:0], digit};
        r_cnt <= r_cnt + 3'd1;
      end
    end
  // A pause freezes the partial count, but a tick already issued this cycle still wraps so it is not reissued on resume.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .i_clr(r_state == LOAD),
    .i_en (running && (!stop_clear || w_tc)),
    .o_tc (w_tc)
  );
  assign load = r_state == LOAD;
  assign running = r_state == RUN;
  assign done = r_state == DONE;
  assign load_value = r_buf;
  assign count_en = running && w_tc && zero_L;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl with a load_value scoreboard
module tb_timer_ctrl;
  logic clk = 0, rst = 0, digit_valid = 0, start = 0, stop_clear = 0, zero_L = 1;
  logic [3:0] digit = 0;
  logic [15:0] load_value;
  logic load, count_en, running, done;
  int n_chk = 0, n_fail = 0;
  logic [15:0] sb[$];
  timer_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit), .start(start),
    .stop_clear(stop_clear), .zero_L(zero_L), .load_value(load_value), .load(load),
    .count_en(count_en), .running(running), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (load === 1'b1) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_load: got load_value %h expected no load", load_value);
      end
      if (sb.size() != 0) begin
        logic [15:0] e;
        e = sb.pop_front();
        n_chk++;
        assert (load_value === e) else begin
          n_fail++;
          $error("FAIL sb_load_value: got %h expected %h", load_value, e);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] eo, input logic [15:0] ev);
    n_chk++;
    assert ({load, running, done, count_en} === eo) else begin
      n_fail++;
      $error("FAIL %s: got {load,running,done,count_en}=%b expected %b", tag, {load, running, done, count_en}, eo);
    end
    n_chk++;
    assert (load_value === ev) else begin
      n_fail++;
      $error("FAIL %s_value: got %h expected %h", tag, load_value, ev);
    end
  endtask
  task automatic key(input logic [3:0] d);
    digit_valid = 1;
    digit = d;
    tick();
    digit_valid = 0;
  endtask
  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic halt();
    stop_clear = 1;
    tick();
    stop_clear = 0;
  endtask
  task automatic reset_pulse();
    rst = 1;
    tick();
    rst = 0;
  endtask
  initial begin
    reset_pulse();
    chk("reset", 4'b0000, 16'h0000);
    key(1); key(2); key(3); key(0);
    chk("entry", 4'b0000, 16'h1230);
    sb.push_back(16'h1230);
    go();
    chk("load", 4'b1000, 16'h1230);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("run%0d", i), (i % 4 == 0) ? 4'b0101 : 4'b0100, 16'h1230);
    end
    tick(); tick(); tick();
    chk("run_pre2", 4'b0100, 16'h1230);
    halt();
    chk("pause", 4'b0000, 16'h1230);
    tick();
    chk("pause_hold", 4'b0000, 16'h1230);
    go();
    chk("resume_pre2", 4'b0100, 16'h1230);
    tick();
    chk("resume_tick", 4'b0101, 16'h1230);
    tick();
    chk("resume_after", 4'b0100, 16'h1230);
    start = 1;
    stop_clear = 1;
    tick();
    start = 0;
    stop_clear = 0;
    chk("both_run_pause", 4'b0000, 16'h1230);
    halt();
    chk("pause_clear", 4'b0000, 16'h0000);
    key(1); key(11); key(2); key(3); key(4); key(5); key(6);
    chk("filter", 4'b0000, 16'h1234);
    halt();
    chk("entry_clear", 4'b0000, 16'h0000);
    go();
    chk("start_empty", 4'b0000, 16'h0000);
    tick();
    chk("start_empty_hold", 4'b0000, 16'h0000);
    key(0); key(0);
    go();
    chk("start_zero", 4'b0000, 16'h0000);
    key(5);
    chk("zero_then_5", 4'b0000, 16'h0005);
    start = 1;
    stop_clear = 1;
    tick();
    start = 0;
    stop_clear = 0;
    chk("both_entry_clear", 4'b0000, 16'h0000);
    key(4); key(2);
    sb.push_back(16'h0042);
    go();
    chk("load42", 4'b1000, 16'h0042);
    tick(); tick(); tick();
    tick();
    zero_L = 0;
    #1;
    chk("zero_no_tick", 4'b0100, 16'h0042);
    tick();
    chk("done", 4'b0010, 16'h0042);
    zero_L = 1;
    tick();
    chk("done_hold", 4'b0010, 16'h0042);
    go();
    chk("done_clear", 4'b0000, 16'h0000);
    key(7);
    sb.push_back(16'h0007);
    go();
    tick(); tick(); tick();
    chk("run_pre2_b", 4'b0100, 16'h0007);
    start = 1;
    reset_pulse();
    start = 0;
    chk("rst_run", 4'b0000, 16'h0000);
    key(3);
    sb.push_back(16'h0003);
    go();
    chk("load3", 4'b1000, 16'h0003);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("rerun%0d", i), (i == 4) ? 4'b0101 : 4'b0100, 16'h0003);
    end
    halt();
    chk("pause_b", 4'b0000, 16'h0003);
    reset_pulse();
    chk("rst_pause", 4'b0000, 16'h0000);
    key(9);
    reset_pulse();
    chk("rst_entry", 4'b0000, 16'h0000);
    key(8);
    sb.push_back(16'h0008);
    go();
    chk("load8", 4'b1000, 16'h0008);
    reset_pulse();
    chk("rst_load", 4'b0000, 16'h0000);
    key(1);
    sb.push_back(16'h0001);
    go();
    tick();
    zero_L = 0;
    tick();
    zero_L = 1;
    chk("done_b", 4'b0010, 16'h0001);
    reset_pulse();
    chk("rst_done", 4'b0000, 16'h0000);
    tick();
    n_chk++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL sb_drain: got %0d pending loads expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control stage directly upstream of the cascaded BCD down-counter chain in the timer. It collects keypad digits into a 4-digit MM:SS entry buffer, drives the counters' parallel `load`, generates the prescaled `count_en` tick for the least significant counter, and watches the chain's aggregated zero flag to stop counting and flag completion. Pause, resume and clear are driven from two pulse inputs.

## Interface
- `TICK_DIV`, 100: clock cycles per count tick; ≥1. Benches use 4.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `digit_valid`  in  1: one-cycle strobe qualifying `digit`.
- `digit`  in  4: BCD keypad digit; values 10–15 are ignored.
- `start`  in  1: one-cycle pulse; load-and-run, or resume.
- `stop_clear`  in  1: one-cycle pulse; pause if running, otherwise clear.
- `zero_L`  in  1: active-low; 0 when all counter digits are zero. This is the AND of the chain's `rco_L` conditions.
- `load_value`  out  16: entry buffer `{m1,m0,s1,s0}`, BCD, drives the counters' `in`.
- `load`  out  1: one-cycle parallel-load pulse to every counter.
- `count_en`  out  1: one-cycle tick to the least significant counter's `enabled`.
- `running`  out  1: high in RUN.
- `done`  out  1: high in DONE.

## Operation
- States: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE.
- Entry buffer:
  - Accepts digits only in IDLE or ENTRY, on `digit_valid` with `digit` ≤ 9.
  - Each accepted digit shifts in from the right: `buf <= {buf[11:0], digit}`.
  - A 3-bit digit count saturates at 4. Once 4 digits are held, further digits are ignored.
  - No MM:SS normalization. Digits load as entered; "0:99" runs 99 ticks through the mod-10 chain.
- Transitions (if `stop_clear` and `start` are high in the same cycle, `stop_clear` wins):
  - IDLE → ENTRY on the first accepted digit, including 0.
  - IDLE/ENTRY → LOAD on `start` when `buf != 0`. When `buf == 0`, `start` is ignored.
  - ENTRY → IDLE on `stop_clear`. Clears the buffer and digit count.
  - LOAD → RUN unconditionally after one cycle. The prescaler is cleared.
  - RUN → PAUSE on `stop_clear`. The prescaler holds its value.
  - RUN → DONE when `zero_L == 0`.
  - PAUSE → RUN on `start`. No reload; the prescaler resumes from its held value.
  - PAUSE → IDLE on `stop_clear`. Clears the buffer.
  - DONE → IDLE on `start` or `stop_clear`. Clears the buffer.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 in RUN only, then wraps to 0.
  - Cleared in LOAD and on reset.
- Outputs:
  - `load = (state==LOAD)`
  - `running = (state==RUN)`
  - `done = (state==DONE)`
  - `load_value = buf`; it stays stable through LOAD/RUN/PAUSE/DONE.
  - `count_en = (state==RUN) && (pre==TICK_DIV-1) && zero_L`. The only Mealy term is `zero_L`. It prevents a 0→9 wrap in the counters.

## Timing
- Reset: state IDLE, buffer 0, digit count 0, prescaler 0. All outputs are 0 the cycle after `rst` is sampled high.
- Reset wins over every input, in every state, including mid-RUN.
- `start` sampled at cycle t: `load`=1 during t+1 only; `running`=1 from t+2.
- Downstream contract: the counters hold `load_value` from t+2. `zero_L` is first evaluated in RUN at t+2.
- First `count_en` occurs in the `TICK_DIV`-th RUN cycle (t+1+`TICK_DIV`). After that it pulses every `TICK_DIV` cycles.
- With `TICK_DIV`=1, `count_en` is high on every RUN cycle while `zero_L`=1.
- Completion: `zero_L` low at cycle u in RUN gives `count_en`=0 at u, `done`=1 at u+1, `running`=0 at u+1.
- Pause: `count_en` is 0 from the cycle after `stop_clear`. Resume preserves the partial tick count.

## Structure
- Shared package `timer_pkg`:
  - state encoding constants (3-bit),
  - BCD digit width (4),
  - digit count (4),
  - default `TICK_DIV`.
- Sub-module `tick_prescaler`:
  - mod-`TICK_DIV` counter with synchronous clear and enable,
  - outputs terminal-count flag `tc`.
  - `timer_ctrl` ANDs `tc` with RUN and `zero_L`.
- Remaining logic in `timer_ctrl`: FSM, entry shift register and digit count.

## Test plan (`TICK_DIV`=4)
- Reset checks: reset in each state, including mid-RUN with pre=2 → next cycle all outputs 0 and state IDLE; `load_value`=16'h0000.
- Load and run: digits 1,2,3,0 then `start` → `load_value`=16'h1230; `load` high exactly one cycle; `running` the next cycle; `count_en` pulses every 4th cycle, first on the 4th RUN cycle.
- Entry filtering: digits 1,11,2,3,4,5,6 → `load_value`=16'h1234 (11 and the fifth/sixth digits ignored); `start` with empty or all-zero buffer → no `load`, state unchanged.
- Pause/resume: RUN with pre=2, `stop_clear` → `count_en` 0, `running` 0. `start` → next `count_en` after 2 cycles, not 4. Two `stop_clear` pulses → IDLE, `load_value`=0. `start`+`stop_clear` together in RUN → PAUSE.
- Completion: drive `zero_L`=0 in the cycle where pre=3 → `count_en` stays 0; `done`=1 next cycle. `start` → IDLE, buffer cleared.
